// File: rtl/lane_buf_pkg.sv
// Shared definitions for the lane ping-pong buffer: back-bank FSM encoding,
// miss counter width and the derived index-width helpers.
package lane_buf_pkg;

  // Back-bank state: FILL accepts writes, READY holds a committed frame.
  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } buf_state_t;

  localparam int MISS_W = 8;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  // Lane index width; a single lane still gets a 1-bit index.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Slot index width; a single slot still gets a 1-bit index.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lane_bank_ram.sv
// One bank of note positions: simple dual-port RAM, one write port and one
// registered read port, addressed {lane, slot}. Contents are not reset.
module lane_bank_ram #(
  parameter int Y_W   = 8,
  parameter int AW    = 6,
  parameter int WORDS = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [Y_W-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [Y_W-1:0] rdata
);

  logic [Y_W-1:0] mem [0:WORDS-1];

  // Write port: store one y-position per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered output, holds its value between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lane_ping_pong_buffer.sv
// Double buffer of per-lane note y-positions. The writer fills the back bank
// and commits; the banks swap at the next unfrozen vsync. The renderer reads
// the front bank through a one-cycle registered read port.
module lane_ping_pong_buffer
  import lane_buf_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int Y_W    = 8,
  parameter int DEPTH  = 16,
  parameter int LANE_W = lane_width(LANES),
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [Y_W-1:0]    wr_y,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              vsync,
  input  logic              freeze,
  input  logic              rd_valid,
  input  logic [LANE_W-1:0] rd_lane,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_y_valid,
  output logic [Y_W-1:0]    rd_y,
  output logic              front_sel,
  output logic [MISS_W-1:0] miss_count
);

  localparam int AW    = LANE_W + ADDR_W;
  localparam int WORDS = LANES * DEPTH;

  buf_state_t        state_reg;
  logic              front_sel_reg;
  logic [1:0]        loaded_reg;
  logic [MISS_W-1:0] miss_reg;
  logic              wr_ready_reg;

  logic              rd_y_valid_reg;
  logic              rd_bank_reg;
  logic              rd_zero_reg;

  logic              wr_lane_ok;
  logic              rd_lane_ok;
  logic              wr_en;
  logic              swap;
  logic              missed;
  logic [1:0]        bank_we;
  logic [Y_W-1:0]    bank_rdata [2];

  // Lane range checks collapse to constant 1 when LANES fills the index space.
  if (LANES == (1 << LANE_W)) begin : g_lane_full
    assign wr_lane_ok = 1'b1;
    assign rd_lane_ok = 1'b1;
  end else begin : g_lane_partial
    assign wr_lane_ok = (wr_lane < LANE_W'(LANES));
    assign rd_lane_ok = (rd_lane < LANE_W'(LANES));
  end

  // A commit arriving together with vsync counts as already committed.
  assign swap   = vsync && !freeze && ((state_reg == READY) || wr_commit);
  assign missed = vsync && !freeze && (state_reg == FILL) && !wr_commit;
  assign wr_en  = !reset && (state_reg == FILL) && wr_valid && wr_lane_ok;

  // Two identical banks; only the back bank (not front_sel) is written.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_we[gi] = wr_en && (front_sel_reg != 1'(gi));

    lane_bank_ram #(
      .Y_W  (Y_W),
      .AW   (AW),
      .WORDS(WORDS)
    ) u_ram (
      .clk  (clk),
      .we   (bank_we[gi]),
      .waddr({wr_lane, wr_addr}),
      .wdata(wr_y),
      .re   (rd_valid && rd_lane_ok),
      .raddr({rd_lane, rd_addr}),
      .rdata(bank_rdata[gi])
    );
  end

  // Back-bank FSM with swap, loaded flags and saturating miss counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILL;
      front_sel_reg <= 1'b0;
      loaded_reg    <= 2'b00;
      miss_reg      <= '0;
      wr_ready_reg  <= 1'b1;
    end else if (swap) begin
      front_sel_reg              <= !front_sel_reg;
      loaded_reg[!front_sel_reg] <= 1'b1;
      state_reg                  <= FILL;
      wr_ready_reg               <= 1'b1;
    end else if (missed) begin
      if (miss_reg != MISS_MAX) begin
        miss_reg <= miss_reg + 1'b1;
      end
    end else if ((state_reg == FILL) && wr_commit) begin
      state_reg    <= READY;
      wr_ready_reg <= 1'b0;
    end
  end

  // Read side: remember which bank was front at issue and whether to force 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_y_valid_reg <= 1'b0;
      rd_bank_reg    <= 1'b0;
      rd_zero_reg    <= 1'b1;
    end else begin
      rd_y_valid_reg <= rd_valid;
      if (rd_valid) begin
        rd_bank_reg <= front_sel_reg;
        rd_zero_reg <= !rd_lane_ok || !loaded_reg[front_sel_reg];
      end
    end
  end

  assign rd_y       = rd_zero_reg ? '0 : bank_rdata[rd_bank_reg];
  assign rd_y_valid = rd_y_valid_reg;
  assign wr_ready   = wr_ready_reg;
  assign front_sel  = front_sel_reg;
  assign miss_count = miss_reg;

endmodule

// File: tb/tb_lane_ping_pong_buffer.sv
// Self-checking bench for lane_ping_pong_buffer: directed scenarios followed by
// randomized traffic, compared every cycle against a frame-level model.
module tb_lane_ping_pong_buffer;

  localparam int LANES  = 3;
  localparam int Y_W    = 8;
  localparam int DEPTH  = 16;
  localparam int LANE_W = 2;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic [LANE_W-1:0] wr_lane;
  logic [ADDR_W-1:0] wr_addr;
  logic [Y_W-1:0]    wr_y;
  logic              wr_commit;
  logic              wr_ready;
  logic              vsync;
  logic              freeze;
  logic              rd_valid;
  logic [LANE_W-1:0] rd_lane;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_y_valid;
  logic [Y_W-1:0]    rd_y;
  logic              front_sel;
  logic [7:0]        miss_count;

  always #5 clk = ~clk;

  lane_ping_pong_buffer #(
    .LANES(LANES),
    .Y_W  (Y_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_lane   (wr_lane),
    .wr_addr   (wr_addr),
    .wr_y      (wr_y),
    .wr_commit (wr_commit),
    .wr_ready  (wr_ready),
    .vsync     (vsync),
    .freeze    (freeze),
    .rd_valid  (rd_valid),
    .rd_lane   (rd_lane),
    .rd_addr   (rd_addr),
    .rd_y_valid(rd_y_valid),
    .rd_y      (rd_y),
    .front_sel (front_sel),
    .miss_count(miss_count)
  );

  // Reference model state: frame-level view of the two banks.
  int m_front;
  int m_committed;
  int m_loaded [2];
  int m_miss;
  int m_mem    [2][4][DEPTH];
  bit m_known  [2][4][DEPTH];
  int e_rvalid;
  int e_ry;
  bit e_rknown;

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                  tag, got, got, exp, exp, $time);
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    wr_lane   = '0;
    wr_addr   = '0;
    wr_y      = '0;
    wr_commit = 1'b0;
    vsync     = 1'b0;
    freeze    = 1'b0;
    rd_valid  = 1'b0;
    rd_lane   = '0;
    rd_addr   = '0;
  endtask

  // Advance the model by one clock using the currently applied inputs.
  task automatic model_edge();
    int l;
    int a;
    if (reset) begin
      m_front     = 0;
      m_committed = 0;
      m_loaded[0] = 0;
      m_loaded[1] = 0;
      m_miss      = 0;
      e_rvalid    = 0;
      e_ry        = 0;
      e_rknown    = 1'b1;
      return;
    end
    e_rvalid = int'(rd_valid);
    if (rd_valid) begin
      l = int'(rd_lane);
      a = int'(rd_addr);
      if (l >= LANES || m_loaded[m_front] == 0) begin
        e_ry     = 0;
        e_rknown = 1'b1;
      end else begin
        e_ry     = m_mem[m_front][l][a];
        e_rknown = m_known[m_front][l][a];
      end
    end
    if (m_committed == 0 && wr_valid && int'(wr_lane) < LANES) begin
      m_mem[1-m_front][wr_lane][wr_addr]   = int'(wr_y);
      m_known[1-m_front][wr_lane][wr_addr] = 1'b1;
    end
    if (vsync && !freeze) begin
      if (m_committed != 0 || wr_commit) begin
        m_front           = 1 - m_front;
        m_loaded[m_front] = 1;
        m_committed       = 0;
      end else if (m_miss < 255) begin
        m_miss = m_miss + 1;
      end
    end else if (wr_commit) begin
      m_committed = 1;
    end
  endtask

  // One clock: model, edge, then compare every observable output.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("front_sel", int'(front_sel), m_front);
    check_eq("wr_ready", int'(wr_ready), (m_committed != 0) ? 0 : 1);
    check_eq("miss_count", int'(miss_count), m_miss);
    check_eq("rd_y_valid", int'(rd_y_valid), e_rvalid);
    if (e_rvalid != 0 && e_rknown) begin
      check_eq("rd_y", int'(rd_y), e_ry);
      $display("read  y=0x%02h exp=0x%02h front=%0d miss=%0d",
               rd_y, e_ry[7:0], front_sel, miss_count);
    end
  endtask

  task automatic do_read(input int l, input int a);
    rd_valid = 1'b1;
    rd_lane  = LANE_W'(l);
    rd_addr  = ADDR_W'(a);
  endtask

  task automatic do_write(input int l, input int a, input int y);
    wr_valid = 1'b1;
    wr_lane  = LANE_W'(l);
    wr_addr  = ADDR_W'(a);
    wr_y     = Y_W'(y);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++)
        for (int a = 0; a < DEPTH; a++) begin
          m_mem[b][l][a]   = 0;
          m_known[b][l][a] = 1'b0;
        end
    m_front = 0; m_committed = 0; m_loaded[0] = 0; m_loaded[1] = 0;
    m_miss = 0; e_rvalid = 0; e_ry = 0; e_rknown = 1'b1;

    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state and first read of an unloaded bank.
    check_eq("rst_front", int'(front_sel), 0);
    check_eq("rst_ready", int'(wr_ready), 1);
    check_eq("rst_miss", int'(miss_count), 0);
    check_eq("rst_rdv", int'(rd_y_valid), 0);
    do_read(0, 0); step(); idle();
    check_eq("t1_rdv", int'(rd_y_valid), 1);
    check_eq("t1_rdy", int'(rd_y), 0);

    // Write (2,5)=0x3C, commit, swap; vsync-cycle read sees old front.
    do_write(2, 5, 8'h3C); step(); idle();
    wr_commit = 1'b1; step(); idle();
    step();
    check_eq("t2_ready_low", int'(wr_ready), 0);
    vsync = 1'b1; do_read(2, 5); step(); idle();
    check_eq("t2_front", int'(front_sel), 1);
    check_eq("t2_vs_read", int'(rd_y), 0);
    check_eq("t2_ready_high", int'(wr_ready), 1);
    do_read(2, 5); step(); idle();
    check_eq("t2_read_3c", int'(rd_y), 8'h3C);

    // Late writer: three vsyncs with no commit.
    repeat (3) begin
      vsync = 1'b1; step(); idle(); step();
    end
    check_eq("t3_miss3", int'(miss_count), 3);
    check_eq("t3_front", int'(front_sel), 1);

    // Freeze holds the committed frame across vsyncs.
    wr_commit = 1'b1; step(); idle();
    freeze = 1'b1; vsync = 1'b1; step();
    vsync = 1'b0; step();
    vsync = 1'b1; step(); idle();
    check_eq("t4_front_held", int'(front_sel), 1);
    check_eq("t4_miss_held", int'(miss_count), 3);
    check_eq("t4_ready_low", int'(wr_ready), 0);
    vsync = 1'b1; step(); idle();
    check_eq("t4_front_swap", int'(front_sel), 0);

    // Saturation: 260 missed vsyncs in total.
    repeat (257) begin
      vsync = 1'b1; step(); idle();
    end
    check_eq("t5_miss_sat", int'(miss_count), 255);

    // Write, commit and vsync together: swap in that cycle with the write.
    do_write(1, 7, 8'h55); wr_commit = 1'b1; vsync = 1'b1; step(); idle();
    check_eq("t6_front", int'(front_sel), 1);
    check_eq("t6_ready", int'(wr_ready), 1);
    do_read(1, 7); step(); idle();
    check_eq("t6_read_55", int'(rd_y), 8'h55);

    // Out-of-range lane: write dropped, read returns 0 with valid.
    do_write(3, 5, 8'hAA); step(); idle();
    wr_commit = 1'b1; step(); idle();
    vsync = 1'b1; step(); idle();
    do_read(3, 5); step(); idle();
    check_eq("t7_bad_lane_v", int'(rd_y_valid), 1);
    check_eq("t7_bad_lane_y", int'(rd_y), 0);

    // Reset while READY discards the committed frame.
    do_write(0, 0, 8'h11); step(); idle();
    wr_commit = 1'b1; step(); idle();
    check_eq("t8_ready_low", int'(wr_ready), 0);
    reset = 1'b1; step(); reset = 1'b0;
    vsync = 1'b1; step(); idle();
    do_read(0, 0); step(); idle();
    check_eq("t8_front", int'(front_sel), 0);
    check_eq("t8_ready", int'(wr_ready), 1);
    check_eq("t8_read0", int'(rd_y), 0);

    // Fill every slot of both banks so random reads have known data.
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < LANES; l++)
        for (int a = 0; a < DEPTH; a++) begin
          do_write(l, a, int'($urandom_range(0, 255))); step(); idle();
        end
      wr_commit = 1'b1; vsync = 1'b1; step(); idle();
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_lane   = LANE_W'($urandom_range(0, 3));
      wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_y      = Y_W'($urandom_range(0, 255));
      wr_commit = ($urandom_range(0, 15) == 0);
      vsync     = ($urandom_range(0, 9) == 0);
      freeze    = ($urandom_range(0, 3) == 0);
      rd_valid  = ($urandom_range(0, 2) != 0);
      rd_lane   = LANE_W'($urandom_range(0, 3));
      rd_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
